// File: rtl/modmul_wlm_out_buf.sv
// Result-side flow control for the fixed-latency WLM modular multiplier: tracks in-flight
// slots, applies the final conditional subtraction and buffers results behind a credit counter.
module modmul_wlm_out_buf #(
    parameter int unsigned LOGQ  = 32,
    parameter int unsigned LOGQH = 15,
    parameter int unsigned LAT   = 6,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [LOGQH-1:0] qH,
    input  logic [LOGQ:0]   T,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [LOGQ-1:0] out_data,
    output logic [CW-1:0]   count
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if (LAT < 1) begin : g_lat_chk
        $error("LAT must be at least 1");
    end
    if (DEPTH < LAT + 1) begin : g_depth_chk
        $error("DEPTH must be at least LAT+1");
    end

    logic [LAT-1:0]  vpipe_q, vpipe_d;
    logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]   fill_q, fill_d, count_q, count_d;
    logic            out_valid_q, out_valid_d;
    logic [LOGQ-1:0] out_data_q, out_data_d;
    logic [LOGQ-1:0] mem_q [DEPTH];

    logic            in_fire, out_fire, cap;
    logic [LOGQ:0]   q_ext, t_sub;
    logic [LOGQ-1:0] wdata;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Credit covers both in-flight and buffered results, so a capture never finds the FIFO full.
    assign in_ready  = (count_q < CW'(DEPTH));
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid_q & out_ready;
    assign cap       = vpipe_q[LAT-1];

    assign q_ext = {1'b0, qH, {(LOGQ - LOGQH - 1){1'b0}}, 1'b1};
    assign t_sub = T - q_ext;
    assign wdata = (T >= q_ext) ? t_sub[LOGQ-1:0] : T[LOGQ-1:0];

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign count     = count_q;

    always_comb begin
        vpipe_d    = vpipe_q << 1;
        vpipe_d[0] = in_fire;
        wptr_d     = cap ? ptr_inc(wptr_q) : wptr_q;
        rptr_d     = out_fire ? ptr_inc(rptr_q) : rptr_q;

        fill_d = fill_q;
        if (cap && !out_fire) begin
            fill_d = fill_q + 1'b1;
        end else if (!cap && out_fire) begin
            fill_d = fill_q - 1'b1;
        end

        count_d = count_q;
        if (in_fire && !out_fire) begin
            count_d = count_q + 1'b1;
        end else if (!in_fire && out_fire) begin
            count_d = count_q - 1'b1;
        end

        out_valid_d = (fill_d != '0);
        out_data_d  = out_data_q;
        // The entry being written becomes the head when nothing older remains after the read.
        if (cap && (fill_q == CW'(out_fire))) begin
            out_data_d = wdata;
        end else if (fill_d != '0) begin
            out_data_d = mem_q[rptr_d];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vpipe_q     <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            fill_q      <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            vpipe_q     <= vpipe_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            fill_q      <= fill_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (cap) begin
            mem_q[wptr_q] <= wdata;
        end
    end

endmodule

// File: tb/tb_modmul_wlm_out_buf.sv
// Directed bench for modmul_wlm_out_buf: models the fixed-latency multiplier as a delay line
// and checks reduction, latency, backpressure, ordering, reset and pointer wrap.
module tb_modmul_wlm_out_buf;

    localparam int LAT   = 6;
    localparam int DEPTH = 8;
    localparam logic [63:0] QV = 64'h0_FFFE_0001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [14:0] qH;
    logic [32:0] T;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  count;

    int total = 0;
    int bad   = 0;

    logic [32:0] t_next;
    logic [32:0] tpipe [LAT];
    logic [31:0] expq [$];
    logic [31:0] got [$];
    logic        hold_chk = 1'b0;
    logic [31:0] held_data;

    modmul_wlm_out_buf #(
        .LOGQ (32),
        .LOGQH(15),
        .LAT  (LAT),
        .DEPTH(DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .qH       (qH),
        .T        (T),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .count    (count)
    );

    always #5 clk = ~clk;

    // Multiplier stand-in: never stalls, never resets.
    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) tpipe[i] <= tpipe[i-1];
        tpipe[0] <= t_next;
    end
    assign T = tpipe[LAT-1];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: bookkeeping on the inputs now applied, then advance to 1ns past the edge.
    task automatic cyc();
        logic fin, fout;
        fin  = in_valid && in_ready;
        fout = out_valid && out_ready;
        chk("count_le_depth", 64'(count <= 4'(DEPTH)), 1);
        chk("in_ready_credit", 64'(in_ready), 64'(count < 4'(DEPTH)));
        if (hold_chk) begin
            chk("hold_valid", 64'(out_valid), 1);
            chk("hold_data", 64'(out_data), 64'(held_data));
        end
        if (fin) expq.push_back(32'(64'(t_next) % QV));
        if (fout) begin
            got.push_back(out_data);
            chk("sb_nonempty", 64'(expq.size() > 0), 1);
            if (expq.size() > 0) chk("order", 64'(out_data), 64'(expq.pop_front()));
        end
        hold_chk  = out_valid && !out_ready;
        held_data = out_data;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int g0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        qH        = 15'h7FFF;
        t_next    = '0;

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 0);
        chk("rst_out_data", 64'(out_data), 0);
        chk("rst_count", 64'(count), 0);
        chk("rst_in_ready", 64'(in_ready), 1);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (3) cyc();

        // Single small operation: visible LAT+1 cycles after issue.
        t_next   = 33'h0_0001_2345;
        in_valid = 1'b1;
        chk("single_in_ready", 64'(in_ready), 1);
        cyc();
        in_valid = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            chk("single_not_yet", 64'(out_valid), 0);
            chk("single_count_inflight", 64'(count), 1);
            cyc();
        end
        chk("single_valid", 64'(out_valid), 1);
        chk("single_data", 64'(out_data), 64'h0001_2345);
        chk("single_count_buf", 64'(count), 1);
        cyc();
        chk("single_count_drained", 64'(count), 0);
        chk("single_valid_drained", 64'(out_valid), 0);

        // Boundary values q, 2q-1, q-1.
        g0 = got.size();
        in_valid = 1'b1;
        t_next = 33'h0_FFFE_0001; cyc();
        t_next = 33'h1_FFFC_0001; cyc();
        t_next = 33'h0_FFFE_0000; cyc();
        in_valid = 1'b0;
        for (int c = 0; c < 20 && got.size() < g0 + 3; c++) cyc();
        chk("bound_count", 64'(got.size() - g0), 3);
        chk("bound_q", 64'(got[g0]), 64'h0000_0000);
        chk("bound_2q_m1", 64'(got[g0+1]), 64'hFFFE_0000);
        chk("bound_q_m1", 64'(got[g0+2]), 64'hFFFE_0000);

        // Backpressure: exactly DEPTH issues while the consumer stalls.
        g0 = got.size();
        n = 0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 12; i++) begin
            t_next = 33'(64'h1000 + 64'(i) * 64'h1111_1111);
            chk("bp_in_ready", 64'(in_ready), 64'(i < DEPTH));
            if (in_valid && in_ready) n++;
            cyc();
        end
        chk("bp_issues", 64'(n), 8);
        in_valid = 1'b0;
        repeat (8) cyc();
        chk("bp_count_full", 64'(count), 8);
        chk("bp_valid", 64'(out_valid), 1);
        out_ready = 1'b1;
        chk("bp_ready_low_at_drain", 64'(in_ready), 0);
        cyc();
        chk("bp_ready_return", 64'(in_ready), 1);
        repeat (7) cyc();
        chk("bp_drained", 64'(got.size() - g0), 8);
        chk("bp_empty_valid", 64'(out_valid), 0);
        chk("bp_empty_count", 64'(count), 0);

        // Streaming with random consumer stalls.
        g0 = got.size();
        n = 0;
        for (int c = 0; c < 3000 && got.size() < g0 + 100; c++) begin
            in_valid  = (n < 100);
            t_next    = 33'({$urandom, $urandom} % (2 * QV));
            out_ready = 1'($urandom_range(0, 1));
            if (in_valid && in_ready) n++;
            cyc();
        end
        in_valid = 1'b0;
        chk("stream_delivered", 64'(got.size() - g0), 100);
        chk("stream_sb_empty", 64'(expq.size()), 0);

        // Reset with 2 buffered and 3 in flight.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        t_next    = 33'h0_0000_0AAA;
        repeat (2) cyc();
        in_valid = 1'b0;
        repeat (7) cyc();
        in_valid = 1'b1;
        t_next   = 33'h0_0000_0BBB;
        repeat (3) cyc();
        in_valid = 1'b0;
        chk("mid_count", 64'(count), 5);
        chk("mid_valid", 64'(out_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 0);
        chk("arst_count", 64'(count), 0);
        chk("arst_in_ready", 64'(in_ready), 1);
        expq.delete();
        hold_chk = 1'b0;
        @(posedge clk);
        #1;
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("post_rst_quiet", 64'(out_valid), 0);
            cyc();
        end

        // Pointer wrap: 20 results through the 8-entry buffer.
        g0 = got.size();
        n = 0;
        for (int c = 0; c < 400 && got.size() < g0 + 20; c++) begin
            in_valid  = (n < 20);
            t_next    = 33'({$urandom, $urandom} % (2 * QV));
            out_ready = 1'((c / 3) % 2);
            if (in_valid && in_ready) n++;
            cyc();
        end
        in_valid = 1'b0;
        chk("wrap_delivered", 64'(got.size() - g0), 20);
        chk("wrap_sb_empty", 64'(expq.size()), 0);
        chk("wrap_final_count", 64'(count), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
